// File: rtl/sd_tone_sequencer.sv
// Step scheduler for the sigma-delta tone generator: plays (K, dwell) table entries
// in order, re-seeding the generator through sd_reset on every tone change.
// Optional linear-chirp ramp per entry is enabled by defining TONE_RAMP_EN.
module sd_tone_sequencer #(
  parameter int BITWIDTH = 40,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int DWELL_W  = 24,
  parameter int SETTLE   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [BITWIDTH-1:0] cfg_kval,
  input  logic [DWELL_W-1:0]  cfg_dwell,
`ifdef TONE_RAMP_EN
  input  logic [BITWIDTH-1:0] cfg_delta,
`endif
  input  logic [AW:0]         num_steps,
  input  logic                loop_en,
  input  logic                start,
  input  logic                stop,
  output logic [BITWIDTH-1:0] kval_out,
  output logic                sd_reset,
  output logic [AW-1:0]       step_idx,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [AW:0]    DEPTH_W    = (AW+1)'(DEPTH);
  localparam logic [SW-1:0]  SETTLE_END = SW'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [BITWIDTH-1:0] kval;
    logic [DWELL_W-1:0]  dwell;
`ifdef TONE_RAMP_EN
    logic [BITWIDTH-1:0] delta;
`endif
  } entry_t;

  state_t             state;
  entry_t             table_q [DEPTH];
  logic [AW:0]        n_lat;
  logic               loop_lat;
  logic [SW-1:0]      settle_cnt;
  logic [DWELL_W-1:0] dwell_cnt;

  entry_t             cur;
  logic [DWELL_W-1:0] dwell_eff;
  logic               expired;
  logic               is_last;
  logic [AW-1:0]      next_idx;
  logic               addr_ok;
  logic               steps_ok;

  always_comb begin
    cur       = table_q[step_idx];
    // A zero dwell still gives the step one RUN cycle.
    dwell_eff = (cur.dwell == '0) ? DWELL_W'(1) : cur.dwell;
    expired   = (dwell_cnt >= dwell_eff);
    is_last   = ({1'b0, step_idx} == (n_lat - (AW+1)'(1)));
    next_idx  = is_last ? '0 : step_idx + AW'(1);
    addr_ok   = ({1'b0, cfg_addr} < DEPTH_W);
    steps_ok  = (num_steps != '0) && (num_steps <= DEPTH_W);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      n_lat      <= '0;
      loop_lat   <= 1'b0;
      settle_cnt <= '0;
      dwell_cnt  <= '0;
      kval_out   <= '0;
      sd_reset   <= 1'b1;
      step_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      // NOTE: the table is register-based and must read back zero after reset,
      // so it is cleared here rather than left to an uninitialised RAM.
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;

      if (cfg_we) begin
        if (state != S_IDLE || !addr_ok) begin
          cfg_err <= 1'b1;
        end else begin
          table_q[cfg_addr].kval  <= cfg_kval;
          table_q[cfg_addr].dwell <= cfg_dwell;
`ifdef TONE_RAMP_EN
          table_q[cfg_addr].delta <= cfg_delta;
`endif
        end
      end

      if (state != S_IDLE && stop) begin
        // Abort: step_idx is deliberately left untouched for readback.
        state    <= S_IDLE;
        sd_reset <= 1'b1;
        kval_out <= '0;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            sd_reset <= 1'b1;
            kval_out <= '0;
            if (start && !stop) begin
              if (steps_ok) begin
                n_lat      <= num_steps;
                loop_lat   <= loop_en;
                step_idx   <= '0;
                settle_cnt <= '0;
                kval_out   <= table_q[0].kval;
                busy       <= 1'b1;
                state      <= S_LOAD;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end

          S_LOAD: begin
            if (settle_cnt == SETTLE_END) begin
              sd_reset  <= 1'b0;
              dwell_cnt <= DWELL_W'(1);
              state     <= S_RUN;
            end else begin
              settle_cnt <= settle_cnt + SW'(1);
            end
          end

          S_RUN: begin
            if (expired) begin
              if (is_last && !loop_lat) begin
                done     <= 1'b1;
                sd_reset <= 1'b1;
                kval_out <= '0;
                state    <= S_DONE;
              end else begin
                step_idx   <= next_idx;
                kval_out   <= table_q[next_idx].kval;
                sd_reset   <= 1'b1;
                settle_cnt <= '0;
                state      <= S_LOAD;
              end
            end else begin
              if (dwell_cnt != '1) dwell_cnt <= dwell_cnt + DWELL_W'(1);
`ifdef TONE_RAMP_EN
              kval_out <= kval_out + cur.delta;
`endif
            end
          end

          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_tone_sequencer.sv
// Directed bench for sd_tone_sequencer: single step, looping table, illegal starts,
// stop, config writes while busy and asynchronous reset mid-sequence.
module tb_sd_tone_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [39:0] cfg_kval;
  logic [23:0] cfg_dwell;
`ifdef TONE_RAMP_EN
  logic [39:0] cfg_delta;
`endif
  logic [3:0]  num_steps;
  logic        loop_en;
  logic        start;
  logic        stop;
  logic [39:0] kval_out;
  logic        sd_reset;
  logic [2:0]  step_idx;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int total = 0;
  int bad   = 0;

  localparam logic [39:0] K0 = 40'h000e2ce2c0;
  localparam logic [39:0] KA = 40'h0011223344;
  localparam logic [39:0] KB = 40'h00aabbccdd;
  localparam logic [39:0] KC = 40'h0f00000001;

  sd_tone_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_kval  (cfg_kval),
    .cfg_dwell (cfg_dwell),
`ifdef TONE_RAMP_EN
    .cfg_delta (cfg_delta),
`endif
    .num_steps (num_steps),
    .loop_en   (loop_en),
    .start     (start),
    .stop      (stop),
    .kval_out  (kval_out),
    .sd_reset  (sd_reset),
    .step_idx  (step_idx),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [39:0] k, input logic [23:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_kval = k; cfg_dwell = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // Pulses start for one edge; on return the bench sits in cycle 1 of the sequence.
  task automatic go(input logic [3:0] n, input logic lp);
    num_steps = n; loop_en = lp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check(tag, busy, 0);
  endtask

  initial begin
    int          lens [3];
    logic [39:0] ks [3];
    int          s, p;

    lens = '{5, 3, 3};
    ks   = '{KA, KB, KC};
    reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_kval = '0; cfg_dwell = '0;
`ifdef TONE_RAMP_EN
    cfg_delta = '0;
`endif
    num_steps = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;

    #12;
    check("rst_kval", kval_out, 0);
    check("rst_sdreset", sd_reset, 1);
    check("rst_idx", step_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", cfg_err, 0);
    reset = 1'b1;
    tick();

    // Single step, dwell 5.
    wr(3'd0, K0, 24'd5);
    go(4'd1, 1'b0);
    check("t1_c1_sdreset", sd_reset, 1);
    check("t1_c1_busy", busy, 1);
    check("t1_c1_kval", kval_out, K0);
    tick();
    check("t1_c2_sdreset", sd_reset, 1);
    for (int c = 3; c <= 7; c++) begin
      tick();
      check("t1_run_sdreset", sd_reset, 0);
      check("t1_run_kval", kval_out, K0);
      check("t1_run_done", done, 0);
    end
    tick();
    check("t1_c8_done", done, 1);
    check("t1_c8_sdreset", sd_reset, 1);
    check("t1_c8_kval", kval_out, 0);
    tick();
    check("t1_c9_busy", busy, 0);
    check("t1_c9_done", done, 0);

    // Illegal step counts.
    go(4'd0, 1'b0);
    check("ns0_err", cfg_err, 1);
    check("ns0_busy", busy, 0);
    check("ns0_kval", kval_out, 0);
    tick();
    check("ns0_err_clr", cfg_err, 0);
    go(4'd9, 1'b0);
    check("ns9_err", cfg_err, 1);
    check("ns9_busy", busy, 0);
    check("ns9_kval", kval_out, 0);

    // Three-entry loop: step lengths SETTLE+dwell = 5, 3, 3.
    wr(3'd0, KA, 24'd3);
    wr(3'd1, KB, 24'd1);
    wr(3'd2, KC, 24'd0);
    go(4'd3, 1'b1);
    s = 0; p = 0;
    for (int c = 1; c <= 22; c++) begin
      check("loop_idx", step_idx, s);
      check("loop_sdreset", sd_reset, (p < 2) ? 1 : 0);
      check("loop_kval", kval_out, ks[s]);
      check("loop_done", done, 0);
      p++;
      if (p == lens[s]) begin
        p = 0;
        s = (s + 1) % 3;
      end
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("loop_stop_busy", busy, 0);
    check("loop_stop_done", done, 0);

    // Stop on the second RUN cycle of step 1 (step 1 dwell 3 -> RUN cycles 8..10).
    wr(3'd1, KB, 24'd3);
    go(4'd2, 1'b0);
    repeat (8) tick();
    check("stop_pre_idx", step_idx, 1);
    check("stop_pre_sdreset", sd_reset, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_sdreset", sd_reset, 1);
    check("stop_kval", kval_out, 0);
    check("stop_done", done, 0);
    check("stop_idx", step_idx, 1);
    tick();
    check("stop_done_late", done, 0);

    // stop and start together in IDLE.
    stop = 1'b1;
    go(4'd1, 1'b0);
    stop = 1'b0;
    check("stopstart_busy", busy, 0);
    check("stopstart_err", cfg_err, 0);

    // num_steps == DEPTH is legal.
    go(4'd8, 1'b0);
    check("ns8_busy", busy, 1);
    check("ns8_err", cfg_err, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("ns8_stop", busy, 0);

    // Config write while busy is rejected.
    go(4'd1, 1'b0);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_kval = 40'h0000001234; cfg_dwell = 24'd9;
    tick();
    cfg_we = 1'b0;
    check("wbusy_err", cfg_err, 1);
    tick();
    check("wbusy_err_clr", cfg_err, 0);
    wait_idle("wbusy_wait_idle");
    go(4'd1, 1'b0);
    check("wbusy_kval_kept", kval_out, KA);
    repeat (5) tick();
    check("wbusy_dwell_kept", done, 1);
    tick();
    check("wbusy_idle", busy, 0);

    // Asynchronous reset mid-RUN.
    go(4'd1, 1'b0);
    repeat (3) tick();
    check("rmid_pre_sdreset", sd_reset, 0);
    #2 reset = 1'b0;
    #1;
    check("rmid_kval", kval_out, 0);
    check("rmid_sdreset", sd_reset, 1);
    check("rmid_busy", busy, 0);
    check("rmid_idx", step_idx, 0);
    tick();
    reset = 1'b1;
    tick();
    go(4'd1, 1'b0);
    check("rpost_kval", kval_out, 0);
    check("rpost_sdreset", sd_reset, 1);
    repeat (2) tick();
    check("rpost_run", sd_reset, 0);
    check("rpost_busy", busy, 1);
    tick();
    check("rpost_done", done, 1);
    tick();
    check("rpost_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_tone_sequencer.md
Name: sd_tone_sequencer

Overview:
- Scheduler for the two-piece sigma-delta tone generator.
- Holds a small table of (K tuning word, dwell) steps and plays them in order.
- Drives the generator's K input and its reset, so the generator is re-seeded cleanly at every tone change.
- Sits between the host config bus and the sigma-delta pair; one sequencer per generator.

Parameters:
- BITWIDTH, 40, width of K tuning word and of kval_out.
- DEPTH, 8, number of table entries (power of two, >=2).
- AW, 3, table address width, equal to log2(DEPTH).
- DWELL_W, 24, width of the per-step dwell count.
- SETTLE, 2, cycles sd_reset is held high on each step load (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low; low clears all state.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  AW  table entry address.
- cfg_kval  in  BITWIDTH  K word to store.
- cfg_dwell  in  DWELL_W  dwell cycles to store.
- num_steps  in  AW+1  active entries 1..DEPTH, sampled at start.
- loop_en  in  1  restart at entry 0 after the last step; sampled at start.
- start  in  1  begin sequence, level-sampled in IDLE.
- stop  in  1  abort sequence.
- kval_out  out  BITWIDTH  K word to the generator; generator forms -K itself.
- sd_reset  out  1  active-high reset to the generator.
- step_idx  out  AW  entry currently loaded or running.
- busy  out  1  high when state != IDLE.
- done  out  1  one-cycle pulse at normal sequence completion.
- cfg_err  out  1  one-cycle pulse on an illegal request.

Behaviour:
- Reset (reset low):
  - Outputs: kval_out=0, sd_reset=1, step_idx=0, busy=0, done=0, cfg_err=0.
  - State: IDLE; all table entries cleared to 0; latched num_steps/loop_en cleared.
- States: IDLE, LOAD, RUN, DONE. All outputs registered.
- IDLE:
  - sd_reset=1, kval_out=0.
  - cfg_we writes entry cfg_addr.
  - start with 1<=num_steps<=DEPTH: latch num_steps and loop_en, step_idx=0, go to LOAD.
  - start with num_steps=0 or >DEPTH: stay in IDLE, pulse cfg_err.
- LOAD:
  - On entry, kval_out = table[step_idx].kval.
  - sd_reset=1 for exactly SETTLE cycles, then go to RUN.
- RUN:
  - sd_reset=0; dwell counter runs for table[step_idx].dwell cycles; dwell=0 is treated as 1.
  - At dwell expiry:
    - step_idx < latched num_steps-1: step_idx+1, go to LOAD.
    - Last step with loop_en: step_idx=0, go to LOAD.
    - Last step without loop_en: go to DONE.
- DONE:
  - One cycle; done=1, sd_reset=1, kval_out=0; then IDLE.
- Timing: start sampled at edge 0 gives LOAD on cycles 1..SETTLE and RUN on cycles SETTLE+1..SETTLE+dwell. The next LOAD begins the following cycle, so a step costs SETTLE+dwell cycles.
- stop:
  - Effective in any non-IDLE state; next cycle is IDLE with sd_reset=1 and kval_out=0.
  - No done pulse; step_idx is held for readback.
  - stop has priority over start and over dwell expiry in the same cycle.
- Config writes:
  - cfg_we while busy is ignored and pulses cfg_err.
  - cfg_we with cfg_addr >= DEPTH is ignored and pulses cfg_err; this only occurs when DEPTH is not 2^AW.
- start while busy is ignored, with no error.
- Reset asserted mid-sequence: immediate asynchronous return to reset values; the generator is forced into reset via sd_reset=1.
- Dwell counter is DWELL_W bits and saturates, with no wrap.

Optional Feature:
- Macro: TONE_RAMP_EN.
- Defined:
  - Adds input cfg_delta (BITWIDTH) and a per-entry delta field.
  - In RUN, kval_out += delta every cycle, modulo 2^BITWIDTH, with two's-complement wrap; this produces linear chirps.
  - Each LOAD reloads the base K value.
- Undefined: port and field are absent; kval_out is constant through RUN.

Test Plan:
- Write entry0={40'h000e2ce2c0, dwell 5}; num_steps=1, loop_en=0, start -> sd_reset high cycles 1-2, kval_out=40'h000e2ce2c0, sd_reset low cycles 3-7, done pulse cycle 8, busy low cycle 9.
- Three entries with dwell 3,1,0 and loop_en=1 -> step_idx sequence 0,1,2,0,1,... Per-step lengths 5,3,3 cycles; no done pulse.
- start with num_steps=0, then num_steps=9 -> cfg_err pulses, busy stays 0, kval_out stays 0.
- stop asserted on the second RUN cycle of step 1 -> next cycle IDLE, sd_reset=1, kval_out=0, done=0, step_idx=1. stop and start asserted together in IDLE -> stays IDLE.
- cfg_we to entry0 while busy -> cfg_err pulse; the entry keeps its old value on the next sequence.
- reset pulled low mid-RUN -> outputs immediately go to reset values; after release, entry0 reads back kval 0 (the sequence plays K=0).
